// File: rtl/balance_payout_pkg.sv
// Shared definitions for the balance accumulator / payout pair.
package balance_payout_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned COUNT_W = 5;

    localparam logic [DIGIT_W-1:0] DENOM_TEN  = 4'd10;
    localparam logic [DIGIT_W-1:0] DENOM_FIVE = 4'd5;
    localparam logic [DIGIT_W-1:0] DENOM_ONE  = 4'd1;
    localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_DONE = 2'd2
    } pay_state_e;

    // Greedy denomination for a remaining balance: tens, then a five, then ones.
    function automatic logic [DIGIT_W-1:0] denom_sel(input logic [DIGIT_W-1:0] tens,
                                                     input logic [DIGIT_W-1:0] ones);
        logic [DIGIT_W-1:0] code;
        if (tens != '0) begin
            code = DENOM_TEN;
        end else if (ones >= DENOM_FIVE) begin
            code = DENOM_FIVE;
        end else begin
            code = DENOM_ONE;
        end
        return code;
    endfunction

    // Out-of-range BCD digits clamp to 9, same as the accumulator overflow rule.
    function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/balance_payout.sv
// Pays a two-digit BCD balance out as a stream of 10/5/1 codes over valid/ready.
module balance_payout
    import balance_payout_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DIGIT_W-1:0]  tens_in,
    input  logic [DIGIT_W-1:0]  ones_in,
    input  logic                abort,
    output logic [DIGIT_W-1:0]  score_out,
    output logic                score_valid,
    input  logic                score_ready,
    output logic                busy,
    output logic                done,
    output logic [DIGIT_W-1:0]  tens_left,
    output logic [DIGIT_W-1:0]  ones_left,
    output logic [COUNT_W-1:0]  code_count
);

    pay_state_e         state_q, state_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [DIGIT_W-1:0] score_out_q, score_out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT_W-1:0] cur_code;
    logic [DIGIT_W-1:0] tens_cap;
    logic [DIGIT_W-1:0] ones_cap;

    // Next-state, remainder arithmetic and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        count_d     = count_q;
        cur_code    = denom_sel(tens_q, ones_q);
        tens_cap    = bcd_sat(tens_in);
        ones_cap    = bcd_sat(ones_in);

        unique case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    tens_d = '0;
                    ones_d = '0;
                end else if (load) begin
                    tens_d  = tens_cap;
                    ones_d  = ones_cap;
                    count_d = '0;
                    state_d = ((tens_cap == '0) && (ones_cap == '0)) ? ST_DONE : ST_PAY;
                end
            end
            ST_PAY: begin
                if (abort) begin
                    tens_d  = '0;
                    ones_d  = '0;
                    state_d = ST_IDLE;
                end else if (valid_q && score_ready) begin
                    if (cur_code == DENOM_TEN) begin
                        tens_d = tens_q - DIGIT_W'(1);
                    end else if (cur_code == DENOM_FIVE) begin
                        ones_d = ones_q - DENOM_FIVE;
                    end else begin
                        ones_d = ones_q - DIGIT_W'(1);
                    end
                    count_d = count_q + COUNT_W'(1);
                    if ((tens_d == '0) && (ones_d == '0)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                tens_d  = '0;
                ones_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                tens_d  = '0;
                ones_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next state/remainder.
        valid_d     = (state_d == ST_PAY);
        score_out_d = valid_d ? denom_sel(tens_d, ones_d) : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tens_q      <= '0;
            ones_q      <= '0;
            count_q     <= '0;
            score_out_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            count_q     <= count_d;
            score_out_q <= score_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign score_out   = score_out_q;
    assign score_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tens_left   = tens_q;
    assign ones_left   = ones_q;
    assign code_count  = count_q;

endmodule
